breakpoint_unit: RTL and testbench

//  Generates the breakpoint requests consumed by the clock control path: hard_breakpoint (PC match on

---
 rtl/breakpoint_unit_pkg.sv | 33 +++
 rtl/breakpoint_unit_bp_comparator_bank.sv | 67 ++++++
 rtl/breakpoint_unit.sv | 139 +++++++++++++
 tb/tb_breakpoint_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/breakpoint_unit_pkg.sv
// Shared constants for the breakpoint unit.
//   bp_state_t    : FSM state encodings (RUN, HALT, SKIP)
//   bp_cause_t    : reason the unit is halted
//   select_cause  : fixed cause priority, ebreak > comparator match > single-step
package breakpoint_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_SKIP = 2'd2
    } bp_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_EBREAK = 2'd1,
        CAUSE_MATCH  = 2'd2,
        CAUSE_STEP   = 2'd3
    } bp_cause_t;

    localparam int HIT_INDEX_WIDTH = 3;

    function automatic bp_cause_t select_cause(
        input logic ebreak,
        input logic match,
        input logic step
    );
        if (ebreak)     return CAUSE_EBREAK;
        else if (match) return CAUSE_MATCH;
        else if (step)  return CAUSE_STEP;
        else            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/breakpoint_unit_bp_comparator_bank.sv
// Bank of programmable PC address comparators.
//   clock, reset_n           : block clock, asynchronous active-low reset
//   bp_write/bp_index        : program comparator bp_index (indices >= NUM_BREAKPOINTS ignored)
//   bp_address/bp_enable     : address and enable written into the selected comparator
//   retire_valid/retire_pc   : retiring instruction to compare against
//   match_any                : at least one enabled comparator equals retire_pc
//   match_index              : lowest-numbered matching comparator (0 when no match)
module bp_comparator_bank
    import breakpoint_unit_pkg::*;
#(
    parameter int NUM_BREAKPOINTS = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int IDX_WIDTH       = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       bp_write,
    input  logic [IDX_WIDTH-1:0]       bp_index,
    input  logic [ADDR_WIDTH-1:0]      bp_address,
    input  logic                       bp_enable,
    input  logic                       retire_valid,
    input  logic [ADDR_WIDTH-1:0]      retire_pc,
    output logic                       match_any,
    output logic [HIT_INDEX_WIDTH-1:0] match_index
);

    logic [ADDR_WIDTH-1:0]      addr_q [NUM_BREAKPOINTS];
    logic [NUM_BREAKPOINTS-1:0] en_q;
    logic [NUM_BREAKPOINTS-1:0] match_vec;

    // Writes land in the registers, so a retire in the same cycle still
    // compares against the previous programming.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
                addr_q[i] <= '0;
            end
            en_q <= '0;
        end else if (bp_write) begin
            for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
                if (int'(bp_index) == i) begin
                    addr_q[i] <= bp_address;
                    en_q[i]   <= bp_enable;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
            match_vec[i] = retire_valid && en_q[i] && (addr_q[i] == retire_pc);
        end
    end

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        match_index = '0;
        for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_index = HIT_INDEX_WIDTH'(i);
            end
        end
    end

    assign match_any = |match_vec;

endmodule

// File: rtl/breakpoint_unit.sv
// Breakpoint request generator for the clock control path.
//   clock, reset_n      : core-domain clock, asynchronous active-low reset
//   retire_*            : retirement stream (pc, ebreak flag)
//   bp_*                : comparator programming port
//   step_mode           : halt after every retired instruction
//   auto_resume         : latched at halt entry; halt then ends on countdown_timed_up
//   resume              : single-cycle resume request
//   countdown_timed_up  : countdown expiry from the break countdown timer
//   hard_breakpoint     : halted on comparator hit or single-step
//   soft_breakpoint     : halted on EBREAK
//   countdown_enable    : halted with auto_resume latched
//   halted              : FSM in HALT
//   hit_index           : comparator that caused the halt (0 otherwise)
//   state_dbg           : current FSM state, for observation
//
// Stream semantics: retire_valid qualifies retire_pc/retire_ebreak for exactly
// the cycle it is high; there is no back-pressure, every qualified retire is
// consumed on the rising edge it is presented.
module breakpoint_unit
    import breakpoint_unit_pkg::*;
#(
    parameter  int NUM_BREAKPOINTS = 4,
    parameter  int ADDR_WIDTH      = 32,
    localparam int BP_IDX_WIDTH    = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       retire_valid,
    input  logic [ADDR_WIDTH-1:0]      retire_pc,
    input  logic                       retire_ebreak,
    input  logic                       bp_write,
    input  logic [BP_IDX_WIDTH-1:0]    bp_index,
    input  logic [ADDR_WIDTH-1:0]      bp_address,
    input  logic                       bp_enable,
    input  logic                       step_mode,
    input  logic                       auto_resume,
    input  logic                       resume,
    input  logic                       countdown_timed_up,
    output logic                       hard_breakpoint,
    output logic                       soft_breakpoint,
    output logic                       countdown_enable,
    output logic                       halted,
    output logic [HIT_INDEX_WIDTH-1:0] hit_index,
    output bp_state_t                  state_dbg
);

    bp_state_t                  state_q, state_d;
    bp_cause_t                  cause_q, cause_d;
    logic [HIT_INDEX_WIDTH-1:0] hit_q, hit_d;
    logic                       ar_q, ar_d;

    logic                       match_any;
    logic [HIT_INDEX_WIDTH-1:0] match_index;
    logic                       match_qualified;
    bp_cause_t                  cause_sel;
    logic                       halt_exit;

    bp_comparator_bank #(
        .NUM_BREAKPOINTS (NUM_BREAKPOINTS),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .IDX_WIDTH       (BP_IDX_WIDTH)
    ) u_bank (
        .clock        (clock),
        .reset_n      (reset_n),
        .bp_write     (bp_write),
        .bp_index     (bp_index),
        .bp_address   (bp_address),
        .bp_enable    (bp_enable),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .match_any    (match_any),
        .match_index  (match_index)
    );

    // In SKIP the first retire is the instruction we just halted on; its
    // comparator hit is masked so resume makes forward progress.
    assign match_qualified = match_any && (state_q == ST_RUN);
    assign cause_sel       = select_cause(retire_ebreak, match_qualified, step_mode);
    // resume and timed_up together still produce a single exit.
    assign halt_exit       = resume || (ar_q && countdown_timed_up);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            hit_q   <= '0;
            ar_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hit_q   <= hit_d;
            ar_q    <= ar_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hit_d   = hit_q;
        ar_d    = ar_q;
        case (state_q)
            ST_RUN, ST_SKIP: begin
                if (retire_valid) begin
                    if (cause_sel != CAUSE_NONE) begin
                        state_d = ST_HALT;
                        cause_d = cause_sel;
                        hit_d   = (cause_sel == CAUSE_MATCH) ? match_index : '0;
                        ar_d    = auto_resume;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                // Retires while halted are ignored; the core clock is gated.
                if (halt_exit) begin
                    state_d = ST_SKIP;
                    cause_d = CAUSE_NONE;
                    hit_d   = '0;
                    ar_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cause_d = CAUSE_NONE;
                hit_d   = '0;
                ar_d    = 1'b0;
            end
        endcase
    end

    assign halted           = (state_q == ST_HALT);
    assign soft_breakpoint  = halted && (cause_q == CAUSE_EBREAK);
    assign hard_breakpoint  = halted && ((cause_q == CAUSE_MATCH) || (cause_q == CAUSE_STEP));
    assign countdown_enable = halted && ar_q;
    assign hit_index        = hit_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_breakpoint_unit.sv
module tb_breakpoint_unit;
    import breakpoint_unit_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        retire_ebreak;
    logic        bp_write;
    logic [1:0]  bp_index;
    logic [31:0] bp_address;
    logic        bp_enable;
    logic        step_mode;
    logic        auto_resume;
    logic        resume;
    logic        countdown_timed_up;
    logic        hard_breakpoint;
    logic        soft_breakpoint;
    logic        countdown_enable;
    logic        halted;
    logic [2:0]  hit_index;
    bp_state_t   state_dbg;

    int checks = 0;
    int errors = 0;

    breakpoint_unit #(
        .NUM_BREAKPOINTS (4),
        .ADDR_WIDTH      (32)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .retire_valid       (retire_valid),
        .retire_pc          (retire_pc),
        .retire_ebreak      (retire_ebreak),
        .bp_write           (bp_write),
        .bp_index           (bp_index),
        .bp_address         (bp_address),
        .bp_enable          (bp_enable),
        .step_mode          (step_mode),
        .auto_resume        (auto_resume),
        .resume             (resume),
        .countdown_timed_up (countdown_timed_up),
        .hard_breakpoint    (hard_breakpoint),
        .soft_breakpoint    (soft_breakpoint),
        .countdown_enable   (countdown_enable),
        .halted             (halted),
        .hit_index          (hit_index),
        .state_dbg          (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks: inputs change 1 time unit after a rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic retire_instr(input logic [31:0] pc, input logic eb);
        retire_valid  = 1'b1;
        retire_pc     = pc;
        retire_ebreak = eb;
        tick();
        retire_valid  = 1'b0;
        retire_ebreak = 1'b0;
    endtask

    task automatic write_bp(input logic [1:0] idx, input logic [31:0] addr, input logic en);
        bp_write   = 1'b1;
        bp_index   = idx;
        bp_address = addr;
        bp_enable  = en;
        tick();
        bp_write   = 1'b0;
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
    endtask

    task automatic pulse_timed_up();
        countdown_timed_up = 1'b1;
        tick();
        countdown_timed_up = 1'b0;
    endtask

    // checkers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic h, input logic hb, input logic sb,
                              input logic ce, input logic [2:0] hi, input bp_state_t st);
        check({tag, ".halted"},  32'(halted),           32'(h));
        check({tag, ".hard"},    32'(hard_breakpoint),  32'(hb));
        check({tag, ".soft"},    32'(soft_breakpoint),  32'(sb));
        check({tag, ".cd_en"},   32'(countdown_enable), 32'(ce));
        check({tag, ".hit_idx"}, 32'(hit_index),        32'(hi));
        check({tag, ".state"},   32'(state_dbg),        32'(st));
    endtask

    initial begin
        reset_n            = 1'b0;
        retire_valid       = 1'b0;
        retire_pc          = '0;
        retire_ebreak      = 1'b0;
        bp_write           = 1'b0;
        bp_index           = '0;
        bp_address         = '0;
        bp_enable          = 1'b0;
        step_mode          = 1'b0;
        auto_resume        = 1'b0;
        resume             = 1'b0;
        countdown_timed_up = 1'b0;

        #12;
        check_outs("reset_held", 0, 0, 0, 0, 3'd0, ST_RUN);
        tick();
        reset_n = 1'b1;
        tick();
        check_outs("after_reset", 0, 0, 0, 0, 3'd0, ST_RUN);

        // bp0 = 0x40: 0x3C passes, 0x40 halts one cycle later
        write_bp(2'd0, 32'h0000_0040, 1'b1);
        retire_instr(32'h0000_003C, 1'b0);
        check_outs("pc3c_no_halt", 0, 0, 0, 0, 3'd0, ST_RUN);
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("bp0_hit", 1, 1, 0, 0, 3'd0, ST_HALT);
        // retire during HALT is ignored, even an ebreak
        retire_instr(32'h0000_0044, 1'b1);
        check_outs("retire_in_halt", 1, 1, 0, 0, 3'd0, ST_HALT);
        // timed_up without auto_resume latched does nothing
        pulse_timed_up();
        check_outs("timed_up_no_ar", 1, 1, 0, 0, 3'd0, ST_HALT);
        pulse_resume();
        check_outs("bp0_resume", 0, 0, 0, 0, 3'd0, ST_SKIP);
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("bp0_skip", 0, 0, 0, 0, 3'd0, ST_RUN);

        // bp1 = bp2 = 0x80: lowest index wins; SKIP masks re-trigger
        write_bp(2'd0, 32'h0000_0040, 1'b0);
        write_bp(2'd1, 32'h0000_0080, 1'b1);
        write_bp(2'd2, 32'h0000_0080, 1'b1);
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("bp1_hit", 1, 1, 0, 0, 3'd1, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("bp1_skip", 0, 0, 0, 0, 3'd0, ST_RUN);
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("bp1_rehit", 1, 1, 0, 0, 3'd1, ST_HALT);
        // write during HALT: disable bp1, so bp2 is next winner
        write_bp(2'd1, 32'h0000_0080, 1'b0);
        check_outs("write_in_halt", 1, 1, 0, 0, 3'd1, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0084, 1'b0);
        check_outs("skip_nomatch", 0, 0, 0, 0, 3'd0, ST_RUN);
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("bp2_hit", 1, 1, 0, 0, 3'd2, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0100, 1'b0);

        // ebreak at bp0 address: ebreak beats match
        write_bp(2'd0, 32'h0000_0040, 1'b1);
        retire_instr(32'h0000_0040, 1'b1);
        check_outs("ebreak_hit", 1, 0, 1, 0, 3'd0, ST_HALT);
        pulse_resume();
        check_outs("ebreak_resume", 0, 0, 0, 0, 3'd0, ST_SKIP);
        // ebreak still halts in SKIP
        retire_instr(32'h0000_0040, 1'b1);
        check_outs("ebreak_in_skip", 1, 0, 1, 0, 3'd0, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0100, 1'b0);
        check_outs("back_to_run", 0, 0, 0, 0, 3'd0, ST_RUN);

        // single-step: three halts
        step_mode = 1'b1;
        retire_instr(32'h0000_0200, 1'b0);
        check_outs("step1", 1, 1, 0, 0, 3'd0, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0204, 1'b0);
        check_outs("step2", 1, 1, 0, 0, 3'd0, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_0208, 1'b0);
        check_outs("step3", 1, 1, 0, 0, 3'd0, ST_HALT);
        // dropping step_mode while halted changes nothing now
        step_mode = 1'b0;
        tick();
        check_outs("step_drop_halt", 1, 1, 0, 0, 3'd0, ST_HALT);
        pulse_resume();
        retire_instr(32'h0000_020C, 1'b0);
        check_outs("step_off", 0, 0, 0, 0, 3'd0, ST_RUN);
        // match beats step: bp2 at 0x80 with step on
        step_mode = 1'b1;
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("match_over_step", 1, 1, 0, 0, 3'd2, ST_HALT);
        step_mode = 1'b0;
        pulse_resume();
        retire_instr(32'h0000_0300, 1'b0);

        // auto-resume via countdown
        auto_resume = 1'b1;
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("ar_halt", 1, 1, 0, 1, 3'd0, ST_HALT);
        auto_resume = 1'b0;
        tick();
        check_outs("ar_latched", 1, 1, 0, 1, 3'd0, ST_HALT);
        pulse_timed_up();
        check_outs("ar_exit", 0, 0, 0, 0, 3'd0, ST_SKIP);
        retire_instr(32'h0000_0600, 1'b0);
        // resume and timed_up in the same cycle: one clean exit
        auto_resume = 1'b1;
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("ar_halt2", 1, 1, 0, 1, 3'd0, ST_HALT);
        auto_resume        = 1'b0;
        resume             = 1'b1;
        countdown_timed_up = 1'b1;
        tick();
        resume             = 1'b0;
        countdown_timed_up = 1'b0;
        check_outs("both_exit", 0, 0, 0, 0, 3'd0, ST_SKIP);
        tick();
        check_outs("both_exit_hold", 0, 0, 0, 0, 3'd0, ST_SKIP);
        retire_instr(32'h0000_0600, 1'b0);

        // asynchronous reset during HALT clears comparators
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("pre_reset_halt", 1, 1, 0, 0, 3'd0, ST_HALT);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 3'd0, ST_RUN);
        tick();
        reset_n = 1'b1;
        tick();
        retire_instr(32'h0000_0040, 1'b0);
        check_outs("bp0_cleared", 0, 0, 0, 0, 3'd0, ST_RUN);
        retire_instr(32'h0000_0080, 1'b0);
        check_outs("bp2_cleared", 0, 0, 0, 0, 3'd0, ST_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
